change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Sequences coin payout when the customer requests cash back.
- Accepts a refund amount and drives three coin hoppers (50, 10 and 5 units) with a greedy largest-coin-first schedule.
- Handles a per-coin eject/ack handshake with each hopper.
- Sits between the cash register logic, which owns the balance and issues the start, and the physical hopper interface.

Parameters:
- AMT_W, 16, width of amount and remaining (matches cash register width).
- CNT_W, 8, width of the coins_out counter.
- TIMEOUT_CYC, 1000, cycles allowed per coin handshake (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  reset; one clock; synchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- amount  input  AMT_W  refund value, latched on the accepted start.
- hopper_ack  input  1  level from hoppers; high while a coin passes the sensor.
- eject_50  output  1  eject request to the 50-unit hopper.
- eject_10  output  1  eject request to the 10-unit hopper.
- eject_5  output  1  eject request to the 5-unit hopper.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- remaining  output  AMT_W  value still owed; after done it holds the unpayable residue (0..4).
- coins_out  output  CNT_W  coins ejected in the current transaction; saturates at all-ones.
- fault  output  1  hopper timeout flag; sticky.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=IDLE.
  - All eject_* = 0; busy=0, done=0, fault=0.
  - remaining=0, coins_out=0, timer cleared.
  - Reset mid-transaction aborts it; no partial subtraction completes.
- States: IDLE, SELECT, EJECT, RELEASE, DONE.
- IDLE:
  - start=1 → remaining<=amount, coins_out<=0, fault<=0, next=SELECT.
  - busy is high from the next cycle.
  - Any start outside IDLE is ignored (no queueing).
- SELECT (exactly 1 cycle), choose the coin:
  - remaining>=50 → 50.
  - else remaining>=10 → 10.
  - else remaining>=5 → 5.
  - else go to DONE.
  - On a coin choice, the selected eject_* is registered high on entry to EJECT.
- EJECT:
  - Exactly one eject_* high, held while hopper_ack=0.
  - On hopper_ack=1: drop eject_*, subtract the coin value from remaining, increment coins_out (saturating), next=RELEASE.
  - Subtraction never underflows, because SELECT guarantees remaining >= coin value.
- RELEASE: all eject_* low; wait for hopper_ack=0, then go to SELECT.
  - An ack held high therefore never counts as two coins.
  - hopper_ack=1 seen in SELECT or RELEASE is ignored.
- DONE: done=1 for exactly 1 cycle, then IDLE.
  - remaining and coins_out hold their values until the next accepted start.
- Eject outputs are mutually exclusive at all times.
- Minimum latency per coin: 3 cycles (SELECT, EJECT with ack, RELEASE with ack low).
- amount=0 or amount<5: start → SELECT → DONE; done is high 2 cycles after start; no eject.
- Residue amount%5 is not paid; it stays in remaining.

Optional Feature:
- Macro: DISPENSE_TIMEOUT_EN.
- Defined:
  - A timer counts cycles spent in EJECT plus RELEASE for the current coin; it clears on entry to EJECT.
  - When the timer reaches TIMEOUT_CYC: all eject_* low, fault<=1, next=DONE (done pulses).
  - remaining keeps the unpaid amount; a coin whose ack never arrived is not subtracted.
  - fault stays high until the next accepted start or reset.
- Not defined: no timer logic; fault tied to 0; the FSM waits indefinitely for the hopper.

Test Plan:
- amount=85, hopper acks each eject after 2 cycles and releases 1 cycle later → eject sequence 50,10,10,10,5; done pulse; remaining=0; coins_out=5; never two ejects high at once.
- amount=37 → ejects 10,10,10,5; remaining=2; coins_out=4.
- amount=0, start at cycle N → done high at cycle N+2; no eject_* asserted; busy high at N+1 and N+2, low at N+3.
- start pulsed again while busy with amount=100 → ignored; first transaction finishes unchanged.
- hopper_ack held high for 10 cycles after one 50 eject (amount=100) → only one subtraction; second eject_50 asserts only after ack falls; final remaining=0.
- rst_n=0 while eject_10 is high → all outputs at reset values after that edge.
- With DISPENSE_TIMEOUT_EN, TIMEOUT_CYC=20, ack never asserted, amount=15 → eject_10 drops after 20 cycles; fault=1; done pulse; remaining=15; coins_out=0.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Change dispenser bus: cash-register request/status plus hopper handshake.
// Optional timeout feature is controlled by DISPENSE_TIMEOUT_EN in the design.
//   start, amount      : payout request from the cash register
//   hopper_ack         : level from the hoppers, high while a coin passes
//   eject_50/10/5      : per-hopper eject requests
//   busy, done         : transaction status
//   remaining          : amount still owed (residue after done)
//   coins_out          : coins paid in this transaction (saturating)
//   fault              : sticky hopper timeout flag
// master = register/hopper side, slave = dispenser.
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             hopper_ack;
  logic             eject_50;
  logic             eject_10;
  logic             eject_5;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] coins_out;
  logic             fault;

  modport master (
    output start, amount, hopper_ack,
    input  eject_50, eject_10, eject_5, busy, done, remaining, coins_out, fault
  );

  modport slave (
    input  start, amount, hopper_ack,
    output eject_50, eject_10, eject_5, busy, done, remaining, coins_out, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer driving 50/10/5 hoppers with eject/ack handshake.
// Ports:
//   clk    : system clock, posedge
//   rst_n  : synchronous active-low reset
//   bus    : change_dispenser_if.slave (request, hopper handshake, status)
// Config macro: DISPENSE_TIMEOUT_EN enables a per-coin hopper timeout that
// raises fault and ends the transaction; without it fault is constant 0.
module change_dispenser #(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  change_dispenser_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_EJECT   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_50   = 2'd1;
  localparam logic [1:0] C_10   = 2'd2;
  localparam logic [1:0] C_5    = 2'd3;

  // A zero timeout would make the per-coin budget meaningless.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("change_dispenser: TIMEOUT_CYC must be nonzero");
  end

  logic [2:0]       state, state_next;
  logic [1:0]       coin, coin_next;
  logic [AMT_W-1:0] remaining_q, remaining_next;
  logic [CNT_W-1:0] coins_q, coins_next;
  logic             fault_q, fault_next;
  logic             eject_50_q, eject_10_q, eject_5_q;
  logic             busy_q, done_q;
  logic             timeout_hit;

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      C_50:    return AMT_W'(50);
      C_10:    return AMT_W'(10);
      C_5:     return AMT_W'(5);
      default: return '0;
    endcase
  endfunction

`ifdef DISPENSE_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TMR_W-1:0] timer;

  // Counts cycles spent on the current coin; SELECT clears it before each EJECT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == S_EJECT || state == S_RELEASE) begin
      timer <= timer + TMR_W'(1);
    end else begin
      timer <= '0;
    end
  end

  assign timeout_hit = (state == S_EJECT || state == S_RELEASE) &&
                       (timer == TMR_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-value logic.
  always_comb begin
    state_next     = state;
    coin_next      = coin;
    remaining_next = remaining_q;
    coins_next     = coins_q;
    fault_next     = fault_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          remaining_next = bus.amount;
          coins_next     = '0;
          fault_next     = 1'b0;
          state_next     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining_q >= AMT_W'(50)) begin
          coin_next  = C_50;
          state_next = S_EJECT;
        end else if (remaining_q >= AMT_W'(10)) begin
          coin_next  = C_10;
          state_next = S_EJECT;
        end else if (remaining_q >= AMT_W'(5)) begin
          coin_next  = C_5;
          state_next = S_EJECT;
        end else begin
          coin_next  = C_NONE;
          state_next = S_DONE;
        end
      end
      S_EJECT: begin
        // An ack on the last budgeted cycle still pays the coin.
        if (bus.hopper_ack) begin
          remaining_next = remaining_q - coin_value(coin);
          coins_next     = (coins_q == {CNT_W{1'b1}}) ? coins_q : coins_q + CNT_W'(1);
          coin_next      = C_NONE;
          state_next     = S_RELEASE;
        end else if (timeout_hit) begin
          fault_next = 1'b1;
          coin_next  = C_NONE;
          state_next = S_DONE;
        end
      end
      S_RELEASE: begin
        // Wait for the sensor to clear so a long ack is counted once.
        if (!bus.hopper_ack) begin
          state_next = S_SELECT;
        end else if (timeout_hit) begin
          fault_next = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        coin_next  = C_NONE;
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; ejects/busy/done are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      coin        <= C_NONE;
      remaining_q <= '0;
      coins_q     <= '0;
      fault_q     <= 1'b0;
      eject_50_q  <= 1'b0;
      eject_10_q  <= 1'b0;
      eject_5_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      coin        <= coin_next;
      remaining_q <= remaining_next;
      coins_q     <= coins_next;
      fault_q     <= fault_next;
      eject_50_q  <= (state_next == S_EJECT) && (coin_next == C_50);
      eject_10_q  <= (state_next == S_EJECT) && (coin_next == C_10);
      eject_5_q   <= (state_next == S_EJECT) && (coin_next == C_5);
      busy_q      <= (state_next != S_IDLE);
      done_q      <= (state_next == S_DONE);
    end
  end

  assign bus.eject_50  = eject_50_q;
  assign bus.eject_10  = eject_10_q;
  assign bus.eject_5   = eject_5_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;
  assign bus.coins_out = coins_q;
  assign bus.fault     = fault_q;

endmodule
